// File: rtl/mandelbrot_cfg_pkg.sv
// rtl/mandelbrot_cfg_pkg.sv - state encoding, defaults and width helper for the Mandelbrot configuration loader
package mandelbrot_cfg_pkg;

    localparam int CFG_WIDTH_DEF = 33;
    localparam logic [CFG_WIDTH_DEF-1:0] BOOT_CFG_DEF = 33'h0_3C00_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_HIGH   = 3'd3,
        ST_LOW    = 3'd4,
        ST_FINISH = 3'd5,
        ST_RENDER = 3'd6
    } cfg_state_e;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mandelbrot_cfg_loader_timer.sv
// rtl/mandelbrot_cfg_loader_timer.sv - loadable down-counter with zero flag for sclk phases and render length
module cfg_phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Holds at zero once expired so a stale phase can never wrap around.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mandelbrot_cfg_loader.sv
// rtl/mandelbrot_cfg_loader.sv - serial config shifter and render pulser for the Mandelbrot core; MANDEL_BOOT_CFG_EN loads BOOT_CFG out of reset
module mandelbrot_cfg_loader
    import mandelbrot_cfg_pkg::*;
#(
    parameter int                   CFG_WIDTH    = CFG_WIDTH_DEF,
    parameter int                   CLK_DIV      = 1,
    parameter int                   RENDER_PULSE = 4,
    parameter logic [CFG_WIDTH-1:0] BOOT_CFG     = CFG_WIDTH'(BOOT_CFG_DEF)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CFG_WIDTH-1:0] cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 auto_render,
    input  logic                 render_req,
    output logic                 busy,
    output logic                 done,
    output logic                 ser_enable,
    output logic                 ser_data,
    output logic                 ser_sclk,
    output logic                 render
);

    localparam int TMR_MAX = (CLK_DIV > RENDER_PULSE) ? CLK_DIV : RENDER_PULSE;
    localparam int TMR_W   = cnt_width(TMR_MAX);
    localparam int CNT_W   = cnt_width(CFG_WIDTH);

    localparam logic [TMR_W-1:0] PHASE_RELOAD  = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] RENDER_RELOAD = TMR_W'(RENDER_PULSE - 1);
    localparam logic [CNT_W-1:0] LAST_COUNT    = CNT_W'(CFG_WIDTH);

`ifdef MANDEL_BOOT_CFG_EN
    localparam bit BOOT_EN = 1'b1;
`else
    localparam bit BOOT_EN = 1'b0;
`endif

    cfg_state_e           state_q, state_d;
    logic [CFG_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 auto_q, auto_d;
    logic                 pend_q, pend_d;
    logic                 en_q, en_d;
    logic                 sclk_q, sclk_d;

    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic                 tmr_zero;

    cfg_phase_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // With the boot feature the reset state sits just past an accept of BOOT_CFG.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT_EN ? ST_PREP : ST_IDLE;
            shreg_q <= BOOT_EN ? BOOT_CFG : '0;
            cnt_q   <= '0;
            auto_q  <= 1'b0;
            pend_q  <= 1'b0;
            en_q    <= 1'b0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            sclk_q  <= sclk_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        auto_d   = auto_q;
        en_d     = en_q;
        sclk_d   = sclk_q;
        tmr_load = 1'b0;
        tmr_val  = PHASE_RELOAD;

        case (state_q)
            ST_IDLE: begin
                // A new word wins over a pending render; the render runs after the load.
                if (cfg_valid) begin
                    shreg_d = cfg_data;
                    auto_d  = auto_render;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                    sclk_d  = 1'b0;
                    state_d = ST_PREP;
                end else if (pend_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = RENDER_RELOAD;
                    state_d  = ST_RENDER;
                end
            end
            ST_PREP: begin
                en_d    = 1'b1;
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                sclk_d   = 1'b1;
                tmr_load = 1'b1;
                state_d  = ST_HIGH;
            end
            ST_HIGH: begin
                if (tmr_zero) begin
                    sclk_d   = 1'b0;
                    shreg_d  = shreg_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    tmr_load = 1'b1;
                    state_d  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tmr_zero) begin
                    if (cnt_q == LAST_COUNT) begin
                        state_d = ST_FINISH;
                    end else begin
                        sclk_d   = 1'b1;
                        tmr_load = 1'b1;
                        state_d  = ST_HIGH;
                    end
                end
            end
            ST_FINISH: begin
                if (auto_q || pend_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = RENDER_RELOAD;
                    state_d  = ST_RENDER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RENDER: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The request that opens a render is consumed by it; later ones re-arm.
        pend_d = pend_q | render_req;
        if (state_d == ST_RENDER && state_q != ST_RENDER) begin
            pend_d = 1'b0;
        end
    end

    assign cfg_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FINISH);
    assign render     = (state_q == ST_RENDER);
    assign ser_enable = en_q;
    assign ser_sclk   = sclk_q;
    assign ser_data   = shreg_q[0];

endmodule
